// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants, fetch states and shift ops
package rf_pkg;
  localparam int W     = 16;
  localparam int NREGS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    OUT  = 2'd3
  } fetch_state_t;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;
endpackage

// File: rtl/shifter.sv
// rtl/shifter.sv - combinational single-bit B-operand shifter
module shifter #(
  parameter int W = rf_pkg::W
) (
  input  logic [W-1:0] data_i,
  input  logic [1:0]   op_i,
  output logic [W-1:0] result_o
);
  import rf_pkg::*;

  always_comb begin
    result_o = data_i;
    unique case (op_i)
      SH_LSL:  result_o = {data_i[W-2:0], 1'b0};
      SH_LSR:  result_o = {1'b0, data_i[W-1:1]};
      SH_ASR:  result_o = {data_i[W-1], data_i[W-1:1]};
      default: result_o = data_i;
    endcase
  end
endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file plus two-read operand sequencer feeding the ALU
module operand_fetch #(
  parameter int NREGS = rf_pkg::NREGS,
  parameter int W     = rf_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   rn,
  input  logic [2:0]   rm,
  input  logic [1:0]   shift,
  input  logic         bsel,
  input  logic [W-1:0] imm,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] Ain,
  output logic [W-1:0] Bin,
  output logic         valid,
  output logic         busy
);
  import rf_pkg::*;

  fetch_state_t state_q, state_d;
  logic [W-1:0] regs_q [NREGS];
  logic [2:0]   rn_q, rm_q;
  logic [1:0]   shift_q;
  logic         bsel_q;
  logic [W-1:0] imm_q;
  logic [W-1:0] ain_q, bin_q;
  logic         valid_q;

  logic         accept, load_a, load_b;
  logic [2:0]   rd_addr;
  logic [W-1:0] rd_data, shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RD_A;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = OUT;
      OUT:     state_d = start ? RD_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    rd_addr = rn_q;
    unique case (state_q)
      IDLE, OUT: accept = start;
      RD_A:      begin load_a = 1'b1; rd_addr = rn_q; end
      RD_B:      begin load_b = 1'b1; rd_addr = rm_q; end
      default:   accept = 1'b0;
    endcase
  end

  // Same-edge writeback to the address being read wins over the stored value.
  assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : regs_q[rd_addr];

  shifter #(.W(W)) u_shifter (
    .data_i   (rd_data),
    .op_i     (shift_q),
    .result_o (shifted)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      bsel_q  <= 1'b0;
      imm_q   <= '0;
      ain_q   <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        rn_q    <= rn;
        rm_q    <= rm;
        shift_q <= shift;
        bsel_q  <= bsel;
        imm_q   <= imm;
      end
      if (load_a) ain_q <= rd_data;
      if (load_b) bin_q <= bsel_q ? imm_q : shifted;
      valid_q <= (state_d == OUT);
    end
  end

  assign Ain   = ain_q;
  assign Bin   = bin_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch with a behavioural register model
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  rn, rm;
  logic [1:0]  shift;
  logic        bsel;
  logic [15:0] imm;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] Ain, Bin;
  logic        valid, busy;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .shift(shift),
    .bsel(bsel), .imm(imm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .Ain(Ain), .Bin(Bin), .valid(valid), .busy(busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  logic [15:0] mregs [8];
  int          n_chk = 0, n_fail = 0;
  int          n_push = 0, n_valid = 0;
  int          cyc = 0, last_valid_cyc = 0, last_gap = 0;
  logic        prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [1:0] op);
    int v;
    v = int'(x);
    case (op)
      2'd1:    return 16'((v * 2) % 65536);
      2'd2:    return 16'(v / 2);
      2'd3:    return 16'(v / 2 + ((v >= 32768) ? 32768 : 0));
      default: return x;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!reset && valid) begin
      n_valid++;
      chk("valid_single_cycle", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("sb_Ain", 32'(Ain), 32'(got.a));
        chk("sb_Bin", 32'(Bin), 32'(got.b));
      end
      last_gap       = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end
    prev_valid = valid;
  end

  task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    @(posedge clk);
    if (we && !reset) mregs[wa] = wd;
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rstep();
    step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
  endtask

  task automatic fetch(input logic [2:0] rn_v, input logic [2:0] rm_v, input logic [1:0] sh_v,
                       input logic bs_v, input logic [15:0] imm_v, input logic junk, input logic rw,
                       input logic we2, input logic [2:0] wa2, input logic [15:0] wd2);
    logic [15:0] ea, eb;
    start = 1'b1; rn = rn_v; rm = rm_v; shift = sh_v; bsel = bs_v; imm = imm_v;
    if (rw) rstep(); else step(1'b0, 3'd0, 16'd0);
    chk("busy_E0", 32'(busy), 32'd1);
    start = junk;
    if (junk) begin
      rn = 3'($urandom_range(0, 7)); rm = 3'($urandom_range(0, 7));
      shift = 2'($urandom_range(0, 3)); bsel = 1'($urandom_range(0, 1)); imm = 16'($urandom);
    end
    if (rw) rstep(); else step(1'b0, 3'd0, 16'd0);
    ea = mregs[rn_v];
    chk("Ain_at_E1", 32'(Ain), 32'(ea));
    chk("busy_E1", 32'(busy), 32'd1);
    step(we2, wa2, wd2);
    eb = bs_v ? imm_v : ref_shift(mregs[rm_v], sh_v);
    sb.push_back('{ea, eb});
    n_push++;
    chk("valid_at_E2", 32'(valid), 32'd1);
    chk("busy_E2", 32'(busy), 32'd1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int v0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
    reset = 1'b1; start = 1'b0; rn = '0; rm = '0; shift = '0; bsel = 1'b0; imm = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_Ain", 32'(Ain), 32'd0);
    chk("reset_Bin", 32'(Bin), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    step(1'b1, 3'd1, 16'h0005);
    step(1'b1, 3'd2, 16'h0003);
    fetch(3'd1, 3'd2, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("basic_Ain", 32'(Ain), 32'h0005);
    chk("basic_Bin", 32'(Bin), 32'h0003);
    step(1'b0, 3'd0, 16'd0);
    chk("basic_valid_drop", 32'(valid), 32'd0);
    chk("basic_busy_drop", 32'(busy), 32'd0);

    step(1'b1, 3'd3, 16'h8001);
    fetch(3'd0, 3'd3, 2'b01, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("shift_lsl", 32'(Bin), 32'h0002);
    fetch(3'd0, 3'd3, 2'b10, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("shift_lsr", 32'(Bin), 32'h4000);
    fetch(3'd0, 3'd3, 2'b11, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("shift_asr", 32'(Bin), 32'hC000);
    fetch(3'd0, 3'd3, 2'b01, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("bsel_imm", 32'(Bin), 32'hFFF0);
    step(1'b0, 3'd0, 16'd0);

    step(1'b1, 3'd4, 16'h1111);
    fetch(3'd0, 3'd4, 2'b01, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h2222);
    chk("forward_Bin", 32'(Bin), 32'h4444);
    step(1'b0, 3'd0, 16'd0);

    // Start held high for six edges: two fetches, junk requests ignored mid-fetch.
    v0 = n_valid;
    fetch(3'd1, 3'd2, 2'b00, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("ignored_start_Ain", 32'(Ain), 32'h0005);
    chk("ignored_start_Bin", 32'(Bin), 32'h0003);
    fetch(3'd4, 3'd1, 2'b00, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    step(1'b0, 3'd0, 16'd0);
    chk("b2b_pulse_count", 32'(n_valid - v0), 32'd2);
    chk("b2b_pulse_gap", 32'(last_gap), 32'd3);
    chk("b2b_idle", 32'(busy), 32'd0);

    start = 1'b1; rn = 3'd1; rm = 3'd2; shift = 2'b00; bsel = 1'b0;
    step(1'b0, 3'd0, 16'd0);
    start = 1'b0;
    step(1'b0, 3'd0, 16'd0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_Ain", 32'(Ain), 32'd0);
    chk("abort_Bin", 32'(Bin), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk("abort_no_valid", 32'(valid), 32'd0);
    fetch(3'd1, 3'd2, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    chk("abort_regs_Ain", 32'(Ain), 32'd0);
    chk("abort_regs_Bin", 32'(Bin), 32'd0);

    for (int n = 0; n < 60; n++) begin
      fetch(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) rstep();
    end

    repeat (3) step(1'b0, 3'd0, 16'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("pulse_total", 32'(n_valid), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting directly upstream of the ALU. Holds the 8 x 16-bit general register file behind a single read port and sequences two reads: Rn into the A operand, then Rm through the shifter into the B operand. It presents Ain/Bin with a one-cycle valid pulse, and accepts ALU results back through a write port at any time.

## Interface
- NREGS, default 8: number of general registers; index width is 3.
- W, default 16: datapath width.
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high. Clears all state.
- start, in, 1: fetch request. Accepted only in IDLE or OUT.
- rn, in, 3: A-source register index, sampled when start is accepted.
- rm, in, 3: B-source register index, sampled when start is accepted.
- shift, in, 2: B shift op, sampled when start is accepted.
  - 00: none.
  - 01: LSL 1.
  - 10: LSR 1, logical.
  - 11: ASR 1.
- bsel, in, 1: sampled when start is accepted. 1 selects imm as B, bypassing register read and shifter.
- imm, in, W: immediate (already sign-extended), sampled when start is accepted.
- wr_en, in, 1: register write enable (ALU writeback).
- wr_addr, in, 3: write index.
- wr_data, in, W: write data.
- Ain, out, W: A operand register.
- Bin, out, W: B operand register.
- valid, out, 1: registered; high for exactly one cycle when Ain/Bin are both new.
- busy, out, 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, RD_A, RD_B, OUT.
  - IDLE: start=1 → RD_A; otherwise stay.
  - RD_A → RD_B unconditionally. On this edge, Ain <= R[rn_q].
  - RD_B → OUT unconditionally. On this edge, Bin <= bsel_q ? imm_q : shift(R[rm_q]). valid goes to 1.
  - OUT: start=1 → RD_A (back-to-back); otherwise → IDLE. valid goes to 0 on leaving OUT.
- start in RD_A or RD_B is ignored, not queued.
- Request fields (rn, rm, shift, bsel, imm) are captured into _q registers on the accepting edge. Later input changes do not affect the fetch.
- Single read port, used in RD_A (address rn_q) and RD_B (address rm_q).
- Write port:
  - R[wr_addr] <= wr_data on any edge with wr_en=1, in every state, including during a fetch.
- Write-through forwarding:
  - If wr_en=1 and wr_addr equals the current read address in RD_A or RD_B, the read returns wr_data, not the stale register.
  - Forwarded data still passes through the shifter.
- Shifter:
  - Output is always W bits; the shifted-out bit is discarded.
  - LSL 1 inserts 0 at bit 0.
  - LSR 1 inserts 0 at bit 15.
  - ASR 1 replicates bit 15.
- Ain/Bin hold their values between fetches. Ain changes only on the RD_A edge; Bin only on the RD_B edge.

## Timing
- Reset values:
  - All R[0..7] = 0.
  - Ain = 0, Bin = 0.
  - valid = 0, busy = 0.
  - State = IDLE; all _q registers = 0.
- Reset mid-fetch aborts immediately. No valid pulse for the aborted request.
- Latency: start sampled at edge E0 gives Ain at E1, Bin at E2, and valid high for the cycle E2–E3.
- Throughput: one fetch per 3 cycles when start is held high. valid pulses every third cycle.
- A write at edge Ek is visible to a read at Ek+1 through the register. A read at the same edge Ek sees it through forwarding.
- A write and a fetch on the same edge to different registers do not interact.

## Structure
- Shared package rf_pkg holds:
  - W and NREGS constants.
  - fetch_state_t enum {IDLE, RD_A, RD_B, OUT}.
  - Shift-op constants SH_NONE, SH_LSL, SH_LSR, SH_ASR (2-bit).
- One sub-module, shifter: combinational; inputs W-bit data and 2-bit op; output W-bit result. It is also instantiable elsewhere in the datapath.
- The register file stays inline: array plus one read mux plus forwarding compare.

## Test plan
- Reset, then write R1=0x0005 and R2=0x0003. Start with rn=1, rm=2, shift=00 → Ain=0x0005 at E1, Bin=0x0003 at E2, valid for 1 cycle, busy high for 3 cycles.
- Shifter, with R3=0x8001:
  - shift=01 → Bin=0x0002.
  - shift=10 → Bin=0x4000.
  - shift=11 → Bin=0xC000.
- bsel=1 with imm=0xFFF0 and rm pointing at a nonzero register → Bin=0xFFF0, unshifted.
- Forwarding: R4=0x1111. Start with rm=4, and in the RD_B cycle drive wr_en, wr_addr=4, wr_data=0x2222, shift=01 → Bin=0x4444.
- Back-to-back and ignored start:
  - Hold start high for 6 cycles → exactly two valid pulses, 3 cycles apart.
  - A start pulse during RD_A changes nothing.
- Reset asserted during RD_B → no valid pulse, Ain=Bin=0, all registers 0, busy=0 immediately (asynchronous).
